pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer, replacing the fixed E→M style stage registers wherever a stage must absorb downstream back-pressure without a combinational ready path. It carries a generic control-bit vector and LANES data words, supports synchronous flush, masks control bits on bubbles, and exposes saturating stall/bubble performance counters.

---
 rtl/pipe_stage_skid.sv | 128 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and a two-entry skid buffer.
// Downstream back-pressure is absorbed by the skid entry, so IN_READY never depends combinationally on OUT_READY.
//
// state | meaning
// EMPTY | no entries held
// BUSY  | main (head) entry only
// FULL  | main entry plus skid entry
module pipe_stage_skid #(
  parameter int WIDTH      = 32,
  parameter int LANES      = 2,
  parameter int CTRL_WIDTH = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic                   FLUSH,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [CTRL_WIDTH-1:0]  IN_CTRL,
  input  logic [LANES*WIDTH-1:0] IN_DATA,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [CTRL_WIDTH-1:0]  OUT_CTRL,
  output logic [LANES*WIDTH-1:0] OUT_DATA,
  output logic [CNT_WIDTH-1:0]   STALL_CNT,
  output logic [CNT_WIDTH-1:0]   BUBBLE_CNT
);

  localparam int DW = LANES * WIDTH;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_e;

  state_e                state_q, state_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
  logic [DW-1:0]         main_data_q, main_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DW-1:0]         skid_data_q, skid_data_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;
  logic [CNT_WIDTH-1:0]  bubble_q, bubble_d;
  logic                  in_fire;
  logic                  out_fire;

  assign IN_READY   = (state_q != FULL);
  assign OUT_VALID  = (state_q != EMPTY);
  assign OUT_CTRL   = OUT_VALID ? main_ctrl_q : '0;
  assign OUT_DATA   = main_data_q;
  assign STALL_CNT  = stall_q;
  assign BUBBLE_CNT = bubble_q;

  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = OUT_VALID & OUT_READY;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    stall_d     = stall_q;
    bubble_d    = bubble_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d     = BUSY;
          main_ctrl_d = IN_CTRL;
          main_data_d = IN_DATA;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_ctrl_d = IN_CTRL;
          main_data_d = IN_DATA;
        end else if (in_fire) begin
          state_d     = FULL;
          skid_ctrl_d = IN_CTRL;
          skid_data_d = IN_DATA;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d     = BUSY;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush drops every entry, including a same-cycle accepted one; data payload is left as-is.
    if (FLUSH) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
    end

    if (OUT_VALID && !OUT_READY && (stall_q != '1))
      stall_d = stall_q + CNT_WIDTH'(1);
    if (!OUT_VALID && OUT_READY && (bubble_q != '1))
      bubble_d = bubble_q + CNT_WIDTH'(1);
  end

  // Stage registers update on the falling edge, matching the neighbouring pipeline stages.
  always_ff @(negedge CLK) begin
    if (CLR) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
      bubble_q    <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_q     <= stall_d;
      bubble_q    <= bubble_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised checks for pipe_stage_skid; a second instance with 4-bit counters
// shares the inputs and is used for the saturation check.
module tb_pipe_stage_skid;

  localparam int W  = 32;
  localparam int L  = 2;
  localparam int C  = 3;
  localparam int DW = W * L;
  localparam int EW = C + DW;

  logic          CLK = 1'b0;
  logic          CLR = 1'b0;
  logic          FLUSH = 1'b0;
  logic          IN_VALID = 1'b0;
  logic [C-1:0]  IN_CTRL = '0;
  logic [DW-1:0] IN_DATA = '0;
  logic          OUT_READY = 1'b0;
  logic          IN_READY, OUT_VALID;
  logic [C-1:0]  OUT_CTRL;
  logic [DW-1:0] OUT_DATA;
  logic [15:0]   STALL_CNT, BUBBLE_CNT;

  logic          in_ready4, out_valid4;
  logic [C-1:0]  out_ctrl4;
  logic [DW-1:0] out_data4;
  logic [3:0]    stall_cnt4, bubble_cnt4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  pipe_stage_skid #(.WIDTH(W), .LANES(L), .CTRL_WIDTH(C), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .CLR(CLR), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_CTRL(IN_CTRL), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_CTRL(OUT_CTRL), .OUT_DATA(OUT_DATA),
    .STALL_CNT(STALL_CNT), .BUBBLE_CNT(BUBBLE_CNT)
  );

  pipe_stage_skid #(.WIDTH(W), .LANES(L), .CTRL_WIDTH(C), .CNT_WIDTH(4)) dut4 (
    .CLK(CLK), .CLR(CLR), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(in_ready4), .IN_CTRL(IN_CTRL), .IN_DATA(IN_DATA),
    .OUT_VALID(out_valid4), .OUT_READY(OUT_READY), .OUT_CTRL(out_ctrl4), .OUT_DATA(out_data4),
    .STALL_CNT(stall_cnt4), .BUBBLE_CNT(bubble_cnt4)
  );

  function automatic logic [DW-1:0] mk(input logic [7:0] v);
    return {24'hC0DE00, v, 24'h000000, v};
  endfunction

  // Inputs change 1 time unit after the falling (active) edge; outputs are read there too.
  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    CLR = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    step(); step();
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    step();
    CLR = 1'b1; IN_VALID = 1'b1; IN_CTRL = 3'b111; IN_DATA = mk(8'h5A); OUT_READY = 1'b1;
    step(); step();
    CLR = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    n_checks++; if (IN_READY !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b want 1", IN_READY); end
    n_checks++; if (OUT_VALID !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
    n_checks++; if (OUT_CTRL !== 3'b000) begin n_errors++; $display("FAIL reset_out_ctrl got %b want 000", OUT_CTRL); end
    n_checks++; if (OUT_DATA !== '0) begin n_errors++; $display("FAIL reset_out_data got %h want 0", OUT_DATA); end
    n_checks++; if (STALL_CNT !== 16'd0) begin n_errors++; $display("FAIL reset_stall got %0d want 0", STALL_CNT); end
    n_checks++; if (BUBBLE_CNT !== 16'd0) begin n_errors++; $display("FAIL reset_bubble got %0d want 0", BUBBLE_CNT); end
  endtask

  task automatic test_bubbles();
    do_reset();
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (10) step();
    n_checks++; if (BUBBLE_CNT !== 16'd10) begin n_errors++; $display("FAIL bubble10 got %0d want 10", BUBBLE_CNT); end
    n_checks++; if (bubble_cnt4 !== 4'd10) begin n_errors++; $display("FAIL bubble10_w4 got %0d want 10", bubble_cnt4); end
    repeat (10) step();
    n_checks++; if (BUBBLE_CNT !== 16'd20) begin n_errors++; $display("FAIL bubble20 got %0d want 20", BUBBLE_CNT); end
    n_checks++; if (bubble_cnt4 !== 4'd15) begin n_errors++; $display("FAIL bubble_sat_w4 got %0d want 15", bubble_cnt4); end
    n_checks++; if (STALL_CNT !== 16'd0) begin n_errors++; $display("FAIL bubble_stall got %0d want 0", STALL_CNT); end
    OUT_READY = 1'b0;
  endtask

  task automatic test_streaming();
    do_reset();
    OUT_READY = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      IN_VALID = 1'b1; IN_CTRL = 3'b101; IN_DATA = mk(8'(i));
      n_checks++; if (IN_READY !== 1'b1) begin n_errors++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, IN_READY); end
      step();
      n_checks++;
      if (OUT_VALID !== 1'b1 || OUT_CTRL !== 3'b101 || OUT_DATA !== mk(8'(i))) begin
        n_errors++;
        $display("FAIL stream_out[%0d] got v=%b c=%b d=%h want v=1 c=101 d=%h", i, OUT_VALID, OUT_CTRL, OUT_DATA, mk(8'(i)));
      end
    end
    IN_VALID = 1'b0;
    step();
    n_checks++; if (OUT_VALID !== 1'b0) begin n_errors++; $display("FAIL stream_drain got %b want 0", OUT_VALID); end
    n_checks++; if (STALL_CNT !== 16'd0) begin n_errors++; $display("FAIL stream_stall got %0d want 0", STALL_CNT); end
    n_checks++; if (BUBBLE_CNT !== 16'd1) begin n_errors++; $display("FAIL stream_bubble got %0d want 1", BUBBLE_CNT); end
    OUT_READY = 1'b0;
  endtask

  task automatic test_back_pressure();
    logic iv_t [11];
    int   idx_t [11];
    logic or_t [11];
    logic ir_t [11];
    logic ov_t [11];
    int   od_t [11];
    iv_t  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    idx_t = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 0, 0};
    or_t  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ir_t  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ov_t  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    od_t  = '{0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 0};
    do_reset();
    for (int c = 0; c < 11; c++) begin
      IN_VALID = iv_t[c]; IN_CTRL = 3'b011; IN_DATA = mk(8'(8'hA0 + idx_t[c])); OUT_READY = or_t[c];
      n_checks++;
      if (IN_READY !== ir_t[c] || OUT_VALID !== ov_t[c]) begin
        n_errors++;
        $display("FAIL bp_hs[%0d] got ir=%b ov=%b want ir=%b ov=%b", c, IN_READY, OUT_VALID, ir_t[c], ov_t[c]);
      end
      if (ov_t[c]) begin
        n_checks++;
        if (OUT_DATA !== mk(8'(8'hA0 + od_t[c])) || OUT_CTRL !== 3'b011) begin
          n_errors++;
          $display("FAIL bp_data[%0d] got c=%b d=%h want c=011 d=%h", c, OUT_CTRL, OUT_DATA, mk(8'(8'hA0 + od_t[c])));
        end
      end else begin
        n_checks++;
        if (OUT_CTRL !== 3'b000) begin n_errors++; $display("FAIL bp_mask[%0d] got %b want 000", c, OUT_CTRL); end
      end
      if (c == 10) begin
        n_checks++; if (STALL_CNT !== 16'd3) begin n_errors++; $display("FAIL bp_stall got %0d want 3", STALL_CNT); end
        n_checks++; if (BUBBLE_CNT !== 16'd1) begin n_errors++; $display("FAIL bp_bubble got %0d want 1", BUBBLE_CNT); end
      end
      step();
    end
    IN_VALID = 1'b0; OUT_READY = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    IN_CTRL = 3'b110;
    IN_VALID = 1'b1; IN_DATA = mk(8'hB0); OUT_READY = 1'b1; step();
    IN_VALID = 1'b1; IN_DATA = mk(8'hB1); OUT_READY = 1'b0; step();
    n_checks++; if (IN_READY !== 1'b0) begin n_errors++; $display("FAIL flush_full got ir=%b want 0", IN_READY); end
    IN_VALID = 1'b1; IN_DATA = mk(8'hB2); FLUSH = 1'b1; step();
    FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    n_checks++;
    if (OUT_VALID !== 1'b0 || OUT_CTRL !== 3'b000 || IN_READY !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_full_after got ov=%b c=%b ir=%b want ov=0 c=000 ir=1", OUT_VALID, OUT_CTRL, IN_READY);
    end
    n_checks++; if (STALL_CNT !== 16'd2) begin n_errors++; $display("FAIL flush_stall got %0d want 2", STALL_CNT); end
    n_checks++; if (BUBBLE_CNT !== 16'd1) begin n_errors++; $display("FAIL flush_bubble got %0d want 1", BUBBLE_CNT); end
    step(); step();
    n_checks++; if (OUT_VALID !== 1'b0) begin n_errors++; $display("FAIL flush_no_ghost got ov=%b want 0", OUT_VALID); end
    IN_VALID = 1'b1; IN_CTRL = 3'b001; IN_DATA = mk(8'hB3); OUT_READY = 1'b0; step();
    n_checks++;
    if (OUT_VALID !== 1'b1 || OUT_DATA !== mk(8'hB3) || OUT_CTRL !== 3'b001) begin
      n_errors++;
      $display("FAIL flush_next got ov=%b c=%b d=%h want ov=1 c=001 d=%h", OUT_VALID, OUT_CTRL, OUT_DATA, mk(8'hB3));
    end
    // Flush from BUSY with a same-cycle accepted entry: both must vanish.
    IN_VALID = 1'b1; IN_DATA = mk(8'hB4); FLUSH = 1'b1;
    n_checks++; if (IN_READY !== 1'b1) begin n_errors++; $display("FAIL flush_busy_ir got %b want 1", IN_READY); end
    step();
    FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    n_checks++;
    if (OUT_VALID !== 1'b0 || OUT_CTRL !== 3'b000) begin
      n_errors++;
      $display("FAIL flush_busy got ov=%b c=%b want ov=0 c=000", OUT_VALID, OUT_CTRL);
    end
    step();
    n_checks++; if (OUT_VALID !== 1'b0) begin n_errors++; $display("FAIL flush_busy_ghost got ov=%b want 0", OUT_VALID); end
    OUT_READY = 1'b0;
  endtask

  task automatic test_random();
    logic [EW-1:0] q[$];
    logic          fin, fout;
    logic [EW-1:0] head;
    do_reset();
    for (int cyc = 0; cyc < 10000 + 20; cyc++) begin
      if (cyc < 10000) begin
        IN_VALID = ($urandom_range(0, 3) != 0);
        IN_CTRL  = C'($urandom);
        IN_DATA  = {$urandom, $urandom};
      end else begin
        IN_VALID = 1'b0;
      end
      OUT_READY = (cyc >= 10000) ? 1'b1 : ($urandom_range(0, 2) != 0);
      fin  = IN_VALID & IN_READY;
      fout = OUT_VALID & OUT_READY;
      if (OUT_VALID) begin
        head = (q.size() != 0) ? q[0] : '0;
        n_checks++;
        if (q.size() == 0 || {OUT_CTRL, OUT_DATA} !== head) begin
          n_errors++;
          $display("FAIL rand_order[%0d] got c=%b d=%h want c=%b d=%h (queued %0d)",
                   cyc, OUT_CTRL, OUT_DATA, head[EW-1:DW], head[DW-1:0], q.size());
        end
      end else begin
        n_checks++;
        if (OUT_CTRL !== 3'b000 || q.size() != 0) begin
          n_errors++;
          $display("FAIL rand_idle[%0d] got c=%b queued=%0d want c=000 queued=0", cyc, OUT_CTRL, q.size());
        end
      end
      if (fout && q.size() != 0) void'(q.pop_front());
      if (fin) q.push_back({IN_CTRL, IN_DATA});
      step();
    end
    n_checks++; if (q.size() != 0) begin n_errors++; $display("FAIL rand_drain got %0d left want 0", q.size()); end
    OUT_READY = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bubbles();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
